// File: rtl/ddr3_line_store.sv
// Line-granular memory model with calibration delay and fixed read/write latencies.
// One request is outstanding at a time; requests are sampled only in IDLE.
module ddr3_line_store #(
  parameter int LINE_W     = 256,
  parameter int DEPTH_LOG2 = 10,
  parameter int INIT_CYC   = 5,
  parameter int RD_LAT     = 3,
  parameter int WR_LAT     = 3,
  parameter int STRICT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic [LINE_W-1:0] data_o,
  input  logic              we_i,
  input  logic              rd_i,
  output logic              ack_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int OFF     = $clog2(LINE_W / 8);
  localparam int HI      = OFF + DEPTH_LOG2;
  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int MAX_A   = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int MAX_LAT = (INIT_CYC > MAX_A) ? INIT_CYC : MAX_A;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [31:0] LOW_MASK = 32'((64'd1 << OFF) - 64'd1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD_WAIT,
    S_WR_WAIT,
    S_ACK
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  oor_q;
  logic [LINE_W-1:0]     wdata_q;
  logic [LINE_W-1:0]     mem [DEPTH];

  logic                  take;
  logic                  rd_done;
  logic                  wr_done;
  logic [DEPTH_LOG2-1:0] idx_in;
  logic                  oor_in;
  logic                  unused_addr;

  assign idx_in      = addr_i[HI-1:OFF];
  assign oor_in      = (STRICT != 0) && ((addr_i >> HI) != 32'd0);
  assign unused_addr = ^(addr_i & LOW_MASK);

  assign ack_o  = (state_q == S_ACK);
  assign busy_o = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    rd_done = 1'b0;
    wr_done = 1'b0;
    case (state_q)
      S_INIT: begin
        if (cnt_q == CNT_W'(INIT_CYC - 1)) begin
          state_d = S_ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (rd_i || we_i) begin
          take    = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = rd_i ? S_RD_WAIT : S_WR_WAIT;
        end
      end
      // The counter starts at 1 on the sample edge, so matching LAT lands ack on edge LAT.
      S_RD_WAIT: begin
        if (cnt_q == CNT_W'(RD_LAT)) begin
          state_d = S_ACK;
          rd_done = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WR_WAIT: begin
        if (cnt_q == CNT_W'(WR_LAT)) begin
          state_d = S_ACK;
          wr_done = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      wdata_q <= '0;
      data_o  <= '0;
      err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        idx_q   <= idx_in;
        oor_q   <= oor_in;
        wdata_q <= data_i;
        if (oor_in) err_o <= 1'b1;
      end
      if (rd_done) data_o <= oor_q ? '0 : mem[idx_q];
    end
  end

  // Array is deliberately outside the reset domain; a reset during WR_WAIT
  // moves the state to INIT before wr_done can ever fire.
  always_ff @(posedge clk) begin
    if (wr_done && !oor_q) mem[idx_q] <= wdata_q;
  end

endmodule

// File: tb/tb_ddr3_line_store.sv
// Directed bench for ddr3_line_store: default instance plus a short-read/long-write instance.
module tb_ddr3_line_store;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  addr;
  logic [255:0] data_in;
  logic [255:0] data_out;
  logic         we, rd, ack, busy, err;

  logic [31:0]  addr2;
  logic [255:0] data_in2;
  logic [255:0] data_out2;
  logic         we2, rd2, ack2, busy2, err2;

  int checks   = 0;
  int failures = 0;
  int lat;

  always #5 clk = ~clk;

  ddr3_line_store dut (
    .clk   (clk),
    .rst   (rst),
    .addr_i(addr),
    .data_i(data_in),
    .data_o(data_out),
    .we_i  (we),
    .rd_i  (rd),
    .ack_o (ack),
    .busy_o(busy),
    .err_o (err)
  );

  ddr3_line_store #(
    .DEPTH_LOG2(4),
    .RD_LAT    (1),
    .WR_LAT    (7)
  ) dut2 (
    .clk   (clk),
    .rst   (rst),
    .addr_i(addr2),
    .data_i(data_in2),
    .data_o(data_out2),
    .we_i  (we2),
    .rd_i  (rd2),
    .ack_o (ack2),
    .busy_o(busy2),
    .err_o (err2)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Counts negedges until ack is seen (bounded); the count includes the sample edge.
  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 40);
  endtask

  task automatic wait_ack2(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack2 && n < 40);
  endtask

  // Issues one request on dut and scrambles addr/data right after the sample edge.
  task automatic do_op(input logic r, input logic w, input logic [31:0] a,
                       input logic [255:0] d, output int n);
    addr    = a;
    data_in = d;
    rd      = r;
    we      = w;
    n       = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        addr    = 32'hDEAD_BEEF;
        data_in = {8{32'h1234_5678}};
      end
    end while (!ack && n < 40);
    rd = 1'b0;
    we = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    addr     = '0;
    data_in  = '0;
    we       = 1'b0;
    rd       = 1'b0;
    addr2    = '0;
    data_in2 = '0;
    we2      = 1'b0;
    rd2      = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_ack",  ack,      '0);
    check("rst_busy", busy,     256'd1);
    check("rst_data", data_out, '0);
    check("rst_err",  err,      '0);

    rst = 1'b1;
    wait_ack(lat);
    check("init_lat", lat, 256'd5);
    @(negedge clk);
    check("init_ack_pulse", ack,  '0);
    check("init_busy",      busy, '0);

    // Write then read 0x40; latency 3 after sample edge -> 4 negedges counted
    do_op(1'b0, 1'b1, 32'h0000_0040, {32{8'hA5}}, lat);
    check("wr_lat", lat, 256'd4);
    check("wr_err", err, '0);
    @(negedge clk);
    check("wr_ack_pulse", ack, '0);

    do_op(1'b1, 1'b0, 32'h0000_0040, '0, lat);
    check("rd_lat",  lat,      256'd4);
    check("rd_data", data_out, {32{8'hA5}});
    check("rd_err",  err,      '0);
    @(negedge clk);
    check("rd_ack_pulse", ack,      '0);
    check("rd_data_hold", data_out, {32{8'hA5}});

    // Simultaneous read and write: read wins, write dropped
    do_op(1'b1, 1'b1, 32'h0000_0020, {32{8'hFF}}, lat);
    check("rdwr_lat",  lat,      256'd4);
    check("rdwr_data", data_out, '0);
    @(negedge clk);
    do_op(1'b1, 1'b0, 32'h0000_0020, '0, lat);
    check("rdwr_after_lat",  lat,      256'd4);
    check("rdwr_after_data", data_out, '0);
    @(negedge clk);

    // Out-of-range write would alias onto line 0 if not suppressed
    do_op(1'b0, 1'b1, 32'h0001_0000, {32{8'h3C}}, lat);
    check("oor_wr_lat", lat, 256'd4);
    check("oor_wr_err", err, 256'd1);
    @(negedge clk);
    do_op(1'b1, 1'b0, 32'h0000_0000, '0, lat);
    check("oor_line0_data", data_out, '0);
    check("oor_err_sticky", err,      256'd1);
    @(negedge clk);
    do_op(1'b1, 1'b0, 32'h0001_0040, '0, lat);
    check("oor_rd_lat",  lat,      256'd4);
    check("oor_rd_data", data_out, '0);
    @(negedge clk);

    // Reset aborts a pending write
    do_op(1'b0, 1'b1, 32'h0000_0060, {32{8'h11}}, lat);
    check("pre_abort_lat", lat, 256'd4);
    @(negedge clk);
    addr    = 32'h0000_0060;
    data_in = {32{8'h22}};
    we      = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_ack_early", ack, '0);
    rst = 1'b0;
    we  = 1'b0;
    @(negedge clk);
    check("abort_no_ack", ack,  '0);
    check("abort_busy",   busy, 256'd1);
    check("abort_err",    err,  '0);
    rst = 1'b1;
    wait_ack(lat);
    check("reinit_lat", lat, 256'd5);
    @(negedge clk);
    do_op(1'b1, 1'b0, 32'h0000_0060, '0, lat);
    check("abort_rd_data", data_out, {32{8'h11}});
    @(negedge clk);

    // dut2: write latency 7, read latency 1, requests held high back to back
    addr2    = 32'h0000_0020;
    data_in2 = {32{8'h5A}};
    we2      = 1'b1;
    wait_ack2(lat);
    check("d2_wr_lat", lat, 256'd8);
    wait_ack2(lat);
    check("d2_wr_period", lat, 256'd9);
    we2 = 1'b0;
    rd2 = 1'b1;
    wait_ack2(lat);
    check("d2_rd_period", lat,       256'd3);
    check("d2_rd_data",   data_out2, {32{8'h5A}});
    wait_ack2(lat);
    check("d2_rd_period2", lat, 256'd3);
    check("d2_err",        err2, '0);
    rd2 = 1'b0;
    @(negedge clk);
    check("d2_ack_pulse", ack2, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
